// File: rtl/cmip_sync_filter_ch.sv
// One channel: N-stage level synchroniser followed by a debounce counter that
// only lets dout follow the synchronised level after FILT stable cycles.
module cmip_sync_filter_ch #(
  parameter int   N       = 2,
  parameter int   FILT    = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // FILT=0 behaves exactly like FILT=1: a single register after the chain.
  localparam int FILT_EFF = (FILT < 1) ? 1 : FILT;
  localparam int CNT_W    = (FILT <= 2) ? 1 : $clog2(FILT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_EFF - 1);

  generate
    if (N < 2) begin : g_bad_depth
      $error("cmip_sync_filter_ch: N must be at least 2");
    end
  endgenerate

  logic [N-1:0]     sync_p;
  logic [CNT_W-1:0] cnt_q;
  logic             s;

  assign s = sync_p[N-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p <= {N{RST_VAL}};
      dout   <= RST_VAL;
      cnt_q  <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_p <= {sync_p[N-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (s != dout) begin
        if (cnt_q == CNT_MAX) begin
          dout  <= s;
          cnt_q <= '0;
          rise  <= s;
          fall  <= ~s;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        // Any return to the current level restarts the stability count.
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/cmip_sync_filter.sv
// Multi-channel async-input synchroniser with per-channel glitch filter and
// registered rise/fall pulses; channels are fully independent.
module cmip_sync_filter #(
  parameter int               WIDTH     = 4,
  parameter int               N         = 2,
  parameter logic [WIDTH-1:0] RST_VALUE = '0,
  parameter int               FILT      = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      cmip_sync_filter_ch #(
        .N       (N),
        .FILT    (FILT),
        .RST_VAL (RST_VALUE[g])
      ) u_ch (
        .clk  (clk),
        .rstn (rstn),
        .din  (din[g]),
        .dout (dout[g]),
        .rise (rise[g]),
        .fall (fall[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_cmip_sync_filter.sv
// Bench for cmip_sync_filter: three instances with different depth/filter/reset
// settings, scored against a sliding-window reference model.
module tb_cmip_sync_filter;

  localparam int NA = 2, FA = 3;
  localparam int NB = 3, FB = 0;
  localparam int NC = 2, FC = 3;
  localparam logic [3:0] RA = 4'b0000, RB = 4'b0000, RC = 4'b1010;

  typedef struct packed {
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic [3:0] din_a, din_b, din_c;
  logic [3:0] dout_a, rise_a, fall_a;
  logic [3:0] dout_b, rise_b, fall_b;
  logic [3:0] dout_c, rise_c, fall_c;

  int checks = 0;
  int errors = 0;

  logic [3:0] ha[$], hb[$], hc[$];
  logic [3:0] da, db, dc;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  cmip_sync_filter #(.WIDTH(4), .N(NA), .RST_VALUE(RA), .FILT(FA)) u_a (
    .clk(clk), .rstn(rstn), .din(din_a), .dout(dout_a), .rise(rise_a), .fall(fall_a));
  cmip_sync_filter #(.WIDTH(4), .N(NB), .RST_VALUE(RB), .FILT(FB)) u_b (
    .clk(clk), .rstn(rstn), .din(din_b), .dout(dout_b), .rise(rise_b), .fall(fall_b));
  cmip_sync_filter #(.WIDTH(4), .N(NC), .RST_VALUE(RC), .FILT(FC)) u_c (
    .clk(clk), .rstn(rstn), .din(din_c), .dout(dout_c), .rise(rise_c), .fall(fall_c));

  // Reference: dout flips at an edge only if the synchronised level seen over the
  // last max(FILT,1) edges since reset all differed from the current dout.
  function automatic exp_t model_edge(input logic [3:0] hist[$], input int n, input int f,
                                      input logic [3:0] rstv, inout logic [3:0] d);
    exp_t e;
    int   t;
    int   fe;
    t  = hist.size() - 1;
    fe = (f < 1) ? 1 : f;
    e  = '0;
    for (int i = 0; i < 4; i++) begin
      bit   upd;
      logic sv;
      upd = 1'b1;
      for (int k = 0; k < fe; k++) begin
        if (t - k < 0) upd = 1'b0;
        else begin
          sv = (t - k - n >= 0) ? hist[t-k-n][i] : rstv[i];
          if (sv == d[i]) upd = 1'b0;
        end
      end
      if (upd) begin
        d[i] = ~d[i];
        if (d[i]) e.rise[i] = 1'b1;
        else      e.fall[i] = 1'b1;
      end
    end
    e.dout = d;
    return e;
  endfunction

  task automatic model_reset();
    ha.delete(); hb.delete(); hc.delete();
    qa.delete(); qb.delete(); qc.delete();
    da = RA; db = RB; dc = RC;
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then
  // advance to just after the edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    din_a = a; din_b = b; din_c = c;
    ha.push_back(a); hb.push_back(b); hc.push_back(c);
    qa.push_back(model_edge(ha, NA, FA, RA, da));
    qb.push_back(model_edge(hb, NB, FB, RB, db));
    qc.push_back(model_edge(hc, NC, FC, RC, dc));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0;
    din_a = 4'b0000; din_b = 4'b0000; din_c = 4'b1010;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dout_a, rise_a, fall_a, dout_b, rise_b, fall_b, dout_c, rise_c, fall_c} !==
        {RA, 8'h00, RB, 8'h00, RC, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: got a=%b/%b/%b b=%b/%b/%b c=%b/%b/%b want a=%b b=%b c=%b, no pulses",
               dout_a, rise_a, fall_a, dout_b, rise_b, fall_b, dout_c, rise_c, fall_c, RA, RB, RC);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(4'b0000, 4'b0000, 4'b1010);
      e = qc.pop_front();
      checks++;
      if ({dout_c, rise_c, fall_c} !== e) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                 k, dout_c, rise_c, fall_c, e.dout, e.rise, e.fall);
      end
    end
  endtask

  task automatic test_latency();
    exp_t e;
    qa.delete(); qb.delete(); qc.delete();
    for (int k = 1; k <= 7; k++) begin
      step(4'b0001, 4'b0000, 4'b1010);
      e = qa.pop_front();
      checks++;
      if ({dout_a, rise_a, fall_a} !== e) begin
        errors++;
        $display("FAIL latency_sb[%0d]: got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                 k, dout_a, rise_a, fall_a, e.dout, e.rise, e.fall);
      end
      if (k == NA + FA - 1 || k == NA + FA || k == NA + FA + 1) begin
        checks++;
        if ({dout_a, rise_a} !== ((k == NA + FA - 1) ? 8'b0000_0000 :
                                  (k == NA + FA)     ? 8'b0001_0001 : 8'b0001_0000)) begin
          errors++;
          $display("FAIL latency_edge%0d: got dout=%b rise=%b", k, dout_a, rise_a);
        end
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   r1, f1;
    logic hi;
    r1 = 0; f1 = 0;
    qa.delete(); qb.delete(); qc.delete();
    for (int k = 0; k < 25; k++) begin
      hi = (k < 2) || (k >= 12 && k < 15);
      step({2'b00, hi, 1'b1}, 4'b0000, 4'b1010);
      e = qa.pop_front();
      r1 += int'(rise_a[1]);
      f1 += int'(fall_a[1]);
      checks++;
      if ({dout_a, rise_a, fall_a} !== e) begin
        errors++;
        $display("FAIL glitch_sb[%0d]: got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                 k, dout_a, rise_a, fall_a, e.dout, e.rise, e.fall);
      end
      if (k == 11) begin
        checks++;
        if (r1 != 0 || f1 != 0 || dout_a[1] !== 1'b0) begin
          errors++;
          $display("FAIL glitch_short: got rises=%0d falls=%0d dout1=%b want 0 0 0", r1, f1, dout_a[1]);
        end
      end
    end
    checks++;
    if (r1 != 1 || f1 != 1) begin
      errors++;
      $display("FAIL glitch_long_pulses: got rises=%0d falls=%0d want 1 1", r1, f1);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    int   pulses;
    logic v;
    pulses = 0;
    qa.delete(); qb.delete(); qc.delete();
    for (int k = 0; k < 28; k++) begin
      v = (k < 20) ? logic'((k / 4) % 2) : 1'b0;
      step(4'b0001, {1'b0, v, 2'b00}, 4'b1010);
      e = qb.pop_front();
      pulses += int'(rise_b[2]) + int'(fall_b[2]);
      checks++;
      if ({dout_b, rise_b, fall_b} !== e) begin
        errors++;
        $display("FAIL bypass_sb[%0d]: got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                 k, dout_b, rise_b, fall_b, e.dout, e.rise, e.fall);
      end
      if (k == 6 || k == 7) begin
        checks++;
        if ({dout_b[2], rise_b[2]} !== ((k == 7) ? 2'b11 : 2'b00)) begin
          errors++;
          $display("FAIL bypass_latency_k%0d: got dout2=%b rise2=%b", k, dout_b[2], rise_b[2]);
        end
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL bypass_pulses: got %0d want 4", pulses);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    qa.delete(); qb.delete(); qc.delete();
    for (int k = 1; k <= 4; k++) begin
      step(4'b1001, 4'b0000, 4'b1010);
      e = qa.pop_front();
      checks++;
      if ({dout_a, rise_a, fall_a} !== e) begin
        errors++;
        $display("FAIL midrst_pre[%0d]: got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                 k, dout_a, rise_a, fall_a, e.dout, e.rise, e.fall);
      end
    end
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({dout_a, rise_a, fall_a, dout_c} !== {RA, 8'h00, RC}) begin
      errors++;
      $display("FAIL midrst_async: got dout_a=%b rise=%b fall=%b dout_c=%b want %b 0000 0000 %b",
               dout_a, rise_a, fall_a, dout_c, RA, RC);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(4'b1001, 4'b0000, 4'b1010);
      e = qa.pop_front();
      checks++;
      if ({dout_a, rise_a, fall_a} !== e) begin
        errors++;
        $display("FAIL midrst_post[%0d]: got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                 k, dout_a, rise_a, fall_a, e.dout, e.rise, e.fall);
      end
      if (k == NA + FA) begin
        checks++;
        if (rise_a !== 4'b1001) begin
          errors++;
          $display("FAIL midrst_rise: got rise=%b want 1001", rise_a);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    qa.delete(); qb.delete(); qc.delete();
    for (int k = 1; k <= 15; k++) begin
      step((k <= 8) ? 4'b0000 : 4'b1111, 4'b0000, 4'b1010);
      e = qa.pop_front();
      checks++;
      if ({dout_a, rise_a, fall_a} !== e) begin
        errors++;
        $display("FAIL simul_sb[%0d]: got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=%b",
                 k, dout_a, rise_a, fall_a, e.dout, e.rise, e.fall);
      end
      if (k == 8 + NA + FA) begin
        checks++;
        if ({dout_a, rise_a, fall_a} !== 12'b1111_1111_0000) begin
          errors++;
          $display("FAIL simul_rise: got dout=%b rise=%b fall=%b want 1111 1111 0000",
                   dout_a, rise_a, fall_a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_bypass();
    test_mid_reset();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
